rgb2gray: RTL



---
 rtl/rgb2gray_pkg.sv | 19 +
 rtl/rgb2gray_gray_mac.sv | 54 +++++
 rtl/rgb2gray.sv | 113 +++++++++++
 3 files changed

// File: rtl/rgb2gray_pkg.sv
// Shared constants and state encoding for the RGB-to-luma preprocessing stage.
package rgb2gray_pkg;

  localparam logic [7:0] COEF_R = 8'd77;
  localparam logic [7:0] COEF_G = 8'd150;
  localparam logic [7:0] COEF_B = 8'd29;
  localparam int         SHIFT  = 8;

  localparam int PIPE_LAT    = 4;
  localparam int BYTE_STRIDE = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rgb2gray_gray_mac.sv
// Two-stage luma datapath: registered weighted products, then sum/shift/saturate.
// Defining GRAY_ROUND_EN adds a half-LSB bias before the shift (round-to-nearest).
module gray_mac
  import rgb2gray_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [23:0] rgb,
  output logic        mid_valid,
  output logic        out_valid,
  output logic [7:0]  y
);

  logic [15:0] prod_r;
  logic [15:0] prod_g;
  logic [15:0] prod_b;
  logic [16:0] sum;
  logic [8:0]  y_wide;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mid_valid <= 1'b0;
      prod_r    <= '0;
      prod_g    <= '0;
      prod_b    <= '0;
    end else begin
      mid_valid <= in_valid;
      prod_r    <= in_valid ? 16'(COEF_R) * 16'(rgb[23:16]) : 16'd0;
      prod_g    <= in_valid ? 16'(COEF_G) * 16'(rgb[15:8])  : 16'd0;
      prod_b    <= in_valid ? 16'(COEF_B) * 16'(rgb[7:0])   : 16'd0;
    end
  end

  // One spare sum bit keeps the saturation test meaningful if coefficients change.
  always_comb begin
    sum = {1'b0, prod_r} + {1'b0, prod_g} + {1'b0, prod_b};
`ifdef GRAY_ROUND_EN
    sum = sum + 17'(1 << (SHIFT - 1));
`endif
    y_wide = sum[SHIFT +: 9];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= 8'd0;
    end else begin
      out_valid <= mid_valid;
      y         <= mid_valid ? (y_wide[8] ? 8'hFF : y_wide[7:0]) : 8'd0;
    end
  end

endmodule

// File: rtl/rgb2gray.sv
// Streams an RGB frame from BRAM, converts each pixel to luma and writes it to the gray BRAM.
// Optional GRAY_ROUND_EN (see gray_mac) selects rounding instead of truncation.
module rgb2gray
  import rgb2gray_pkg::*;
#(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        done,
  output logic [31:0] src_addr,
  input  logic [31:0] src_dout,
  output logic        src_en,
  output logic [31:0] dst_addr,
  output logic [31:0] dst_din,
  output logic [3:0]  dst_we
);

  localparam int N_PIX  = IMG_WIDTH * IMG_HEIGHT;
  localparam int IDX_W  = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  localparam int DCNT_W = $clog2(PIPE_LAT);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N_PIX - 1);
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(PIPE_LAT - 1);

  state_t state;
  state_t state_next;

  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [DCNT_W-1:0] drain_cnt;
  logic              rd_valid;
  logic              mid_valid;
  logic              mac_valid;
  logic [7:0]        mac_y;
  logic              unused_alpha;

  assign unused_alpha = ^src_dout[31:24];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (rd_idx == LAST_IDX) state_next = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_LAST) state_next = DONE;
      DONE:    if (!start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign done = (state == DONE);

  // Read side: address and enable are registered, so index k is on the bus one cycle after issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_en   <= 1'b0;
      src_addr <= 32'd0;
      rd_idx   <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= src_en;
      if (state == RUN) begin
        src_en   <= 1'b1;
        src_addr <= 32'(rd_idx) * 32'(BYTE_STRIDE);
        if (rd_idx != LAST_IDX) rd_idx <= rd_idx + 1'b1;
      end else begin
        src_en   <= 1'b0;
        src_addr <= 32'd0;
        rd_idx   <= '0;
      end
    end
  end

  // Counts the pipeline flush so DONE lands right after the last write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 drain_cnt <= '0;
    else if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
    else                     drain_cnt <= '0;
  end

  gray_mac u_mac (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_valid),
    .rgb       (src_dout[23:0]),
    .mid_valid (mid_valid),
    .out_valid (mac_valid),
    .y         (mac_y)
  );

  // Pixels retire in issue order, so a separate write counter stays aligned with the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx   <= '0;
      dst_addr <= 32'd0;
    end else if (state == IDLE) begin
      wr_idx <= '0;
    end else if (mid_valid) begin
      dst_addr <= 32'(wr_idx) * 32'(BYTE_STRIDE);
      if (wr_idx != LAST_IDX) wr_idx <= wr_idx + 1'b1;
    end
  end

  assign dst_we  = {4{mac_valid}};
  assign dst_din = {24'd0, mac_y};

endmodule
